// File: rtl/sonar_scan_n_if.sv
// sonar_scan_n_if: sensor, result and status bundle for the sonar scan controller.
// SONAR_MASK_EN adds the per-channel ch_enable input.
interface sonar_scan_n_if #(parameter int N_CH = 3);
    logic                start;
    logic                continuous;
    logic [N_CH-1:0]     echo;
    logic [N_CH-1:0]     trigger;
    logic [12*N_CH-1:0]  medidas;
    logic [N_CH-1:0]     timeout;
    logic                valid;
    logic [2:0]          ch_idx;
    logic                busy;
    logic                pronto;
    logic [3:0]          db_estado;
`ifdef SONAR_MASK_EN
    logic [N_CH-1:0]     ch_enable;
    modport slave (input start, continuous, echo, ch_enable,
                   output trigger, medidas, timeout, valid, ch_idx, busy, pronto, db_estado);
    modport master (output start, continuous, echo, ch_enable,
                    input trigger, medidas, timeout, valid, ch_idx, busy, pronto, db_estado);
`else
    modport slave (input start, continuous, echo,
                   output trigger, medidas, timeout, valid, ch_idx, busy, pronto, db_estado);
    modport master (output start, continuous, echo,
                    input trigger, medidas, timeout, valid, ch_idx, busy, pronto, db_estado);
`endif
endinterface

// File: rtl/sonar_scan_n.sv
// sonar_scan_n: round-robin HC-SR04 scan controller measuring echoes directly in BCD cm.
// Optional SONAR_MASK_EN: ch_enable skips masked channels and holds their results.
module sonar_scan_n #(
    parameter int N_CH           = 3,
    parameter int TRIG_CYCLES    = 500,
    parameter int CYC_PER_CM     = 2941,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GAP_CYCLES     = 50000
) (
    input logic           clock,
    input logic           reset,
    sonar_scan_n_if.slave bus
);
    localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        TRIG      = 4'd1,
        WAIT_ECHO = 4'd2,
        MEASURE   = 4'd3,
        STORE     = 4'd4,
        GAP       = 4'd5,
        DONE      = 4'd6
    } state_t;
    state_t state, state_n;
    logic [N_CH-1:0] e1, e2, en, tmo;
    logic [12*N_CH-1:0] med;
    logic [31:0] cnt, pre;
    logic [11:0] acc;
    logic [CW-1:0] ch, ch_d, first, nxt;
    logic has_first, has_nxt, ld_ch, set_to, tflag, es, to, tick;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        if (v == 12'h999) return v;
        if (v[3:0] != 4'd9) return v + 12'd1;
        if (v[7:4] != 4'd9) return {v[11:8], v[7:4] + 4'd1, 4'd0};
        return {v[11:8] + 4'd1, 8'h00};
    endfunction

`ifdef SONAR_MASK_EN
    assign en = bus.ch_enable;
`else
    assign en = '1;
`endif

    assign es   = e2[ch];
    assign to   = cnt >= 32'(TIMEOUT_CYCLES - 1);
    assign tick = pre == 32'(CYC_PER_CM - 1);

    // Lowest enabled channel overall, and lowest enabled channel above the current one.
    always_comb begin
        first = '0;
        nxt = '0;
        has_first = 1'b0;
        has_nxt = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en[i]) begin
                first = CW'(i);
                has_first = 1'b1;
            end
            if (en[i] && CW'(i) > ch) begin
                nxt = CW'(i);
                has_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        ld_ch = 1'b0;
        ch_d = ch;
        set_to = 1'b0;
        case (state)
            IDLE, DONE:
                if ((state == IDLE && bus.start) || (state == DONE && bus.continuous)) begin
                    ld_ch = 1'b1;
                    ch_d = first;
                    state_n = has_first ? TRIG : DONE;
                end else state_n = IDLE;
            TRIG: if (cnt == 32'(TRIG_CYCLES - 1)) state_n = WAIT_ECHO;
            WAIT_ECHO:
                if (es) state_n = MEASURE;
                else if (to) begin
                    state_n = STORE;
                    set_to = 1'b1;
                end
            MEASURE:
                if (!es) state_n = STORE;
                else if (to) begin
                    state_n = STORE;
                    set_to = 1'b1;
                end
            STORE: state_n = GAP;
            GAP:
                if (cnt == 32'(GAP_CYCLES - 1)) begin
                    ld_ch = has_nxt;
                    ch_d = nxt;
                    state_n = has_nxt ? TRIG : DONE;
                end
            default: state_n = IDLE;
        endcase
    end

    // cnt times each state, but runs on across WAIT_ECHO->MEASURE so it spans trigger fall to echo fall.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            e1 <= '0;
            e2 <= '0;
            cnt <= '0;
            pre <= '0;
            acc <= '0;
            ch <= '0;
            tflag <= 1'b0;
            med <= '0;
            tmo <= '0;
        end else begin
            e1 <= bus.echo;
            e2 <= e1;
            cnt <= (state_n != state && !(state == WAIT_ECHO && state_n == MEASURE)) ? '0 : cnt + 32'd1;
            if (state == TRIG) begin
                pre <= '0;
                acc <= '0;
            end else if ((state == WAIT_ECHO || state == MEASURE) && es) begin
                pre <= tick ? '0 : pre + 32'd1;
                if (tick) acc <= bcd_inc(acc);
            end
            tflag <= state == TRIG ? 1'b0 : tflag | set_to;
            if (ld_ch) ch <= ch_d;
            if (state == STORE) begin
                med[12*ch +: 12] <= tflag ? 12'h999 : acc;
                tmo[ch] <= tflag;
            end
        end

    assign bus.trigger   = state == TRIG ? N_CH'(1) << ch : '0;
    assign bus.medidas   = med;
    assign bus.timeout   = tmo;
    assign bus.valid     = state == STORE;
    assign bus.ch_idx    = 3'(ch);
    assign bus.busy      = state != IDLE;
    assign bus.pronto    = state == DONE;
    assign bus.db_estado = state;
endmodule
